// File: rtl/bfly_lanes_pipe.sv
`default_nettype none
`timescale 1ns/1ps
// bfly_lanes_pipe: LANES parallel modular butterflies (CT, GS, add/sub, mult) mod Q
// sharing one stallable control path; fixed latency MUL_LAT+2 for every mode.
module bfly_lanes_pipe #(
  parameter int DW      = 12,
  parameter int Q       = 3329,
  parameter int LANES   = 2,
  parameter int MUL_LAT = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          mode,
  input  logic [LANES*DW-1:0] a,
  input  logic [LANES*DW-1:0] b,
  input  logic [LANES*DW-1:0] w,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [LANES*DW-1:0] e,
  output logic [LANES*DW-1:0] o,
  output logic [1:0]          out_mode,
  output logic                range_err,
  input  logic                clr_err
);

  localparam logic [1:0] MODE_CT  = 2'b00;
  localparam logic [1:0] MODE_GS  = 2'b01;
  localparam logic [1:0] MODE_AS  = 2'b10;
  localparam logic [1:0] MODE_MUL = 2'b11;

  localparam logic [DW:0]     QX = (DW+1)'(Q);
  localparam logic [2*DW-1:0] QP = (2*DW)'(Q);

  function automatic logic [DW-1:0] mod_add(input logic [DW-1:0] x, input logic [DW-1:0] y);
    logic [DW:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= QX) s = s - QX;
    return DW'(s);
  endfunction

  function automatic logic [DW-1:0] mod_sub(input logic [DW-1:0] x, input logic [DW-1:0] y);
    logic [DW:0] d;
    if (x >= y) d = {1'b0, x} - {1'b0, y};
    else        d = {1'b0, x} + QX - {1'b0, y};
    return DW'(d);
  endfunction

  // Multiply by inv2 without a multiplier: make the value even by adding Q, then shift.
  function automatic logic [DW-1:0] mod_half(input logic [DW-1:0] x);
    logic [DW:0] t;
    t = x[0] ? ({1'b0, x} + QX) : {1'b0, x};
    return DW'(t >> 1);
  endfunction

  logic               accept;
  logic [LANES-1:0]   lane_bad;
  logic               v1;
  logic [1:0]         m1;
  logic [MUL_LAT-1:0] vm;
  logic [1:0]         mm [MUL_LAT];
  logic               vc;
  logic [1:0]         mc;

  // Global stall: the whole pipe advances only when the output slot can move.
  assign in_ready = out_ready || !out_valid;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1        <= 1'b0;
      m1        <= '0;
      vm        <= '0;
      for (int k = 0; k < MUL_LAT; k++) mm[k] <= '0;
      vc        <= 1'b0;
      mc        <= '0;
      out_valid <= 1'b0;
      out_mode  <= '0;
    end else if (in_ready) begin
      v1    <= in_valid;
      m1    <= mode;
      vm[0] <= v1;
      mm[0] <= m1;
      for (int k = 1; k < MUL_LAT; k++) begin
        vm[k] <= vm[k-1];
        mm[k] <= mm[k-1];
      end
      vc        <= vm[MUL_LAT-1];
      mc        <= mm[MUL_LAT-1];
      out_valid <= vc;
      out_mode  <= mc;
    end
  end

  // A new violation takes priority over a concurrent clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      range_err <= 1'b0;
    else if (accept && |lane_bad) range_err <= 1'b1;
    else if (clr_err)             range_err <= 1'b0;
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [DW-1:0]   ai, bi, wi, sum_in, dif_in;
    logic [DW-1:0]   a1, s1, d1, x1, w1;
    logic [2*DW-1:0] prod;
    logic [DW-1:0]   mp [MUL_LAT];
    logic [DW-1:0]   ad [MUL_LAT];
    logic [DW-1:0]   sd [MUL_LAT];
    logic [DW-1:0]   dd [MUL_LAT];
    logic [DW-1:0]   pm, am, ce, co, ce_r, co_r, e_r, o_r;

    assign ai     = a[i*DW +: DW];
    assign bi     = b[i*DW +: DW];
    assign wi     = w[i*DW +: DW];
    assign sum_in = mod_add(ai, bi);
    assign dif_in = mod_sub(ai, bi);

    assign lane_bad[i] = ({1'b0, bi} >= QX)
                       | ((mode != MODE_MUL) && ({1'b0, ai} >= QX))
                       | ((mode != MODE_AS)  && ({1'b0, wi} >= QX));

    // The single multiplier sees (a-b) for GS and b for every other mode.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        a1 <= '0;
        s1 <= '0;
        d1 <= '0;
        x1 <= '0;
        w1 <= '0;
      end else if (in_ready) begin
        a1 <= ai;
        s1 <= sum_in;
        d1 <= dif_in;
        x1 <= (mode == MODE_GS) ? dif_in : bi;
        w1 <= wi;
      end
    end

    assign prod = {{DW{1'b0}}, x1} * {{DW{1'b0}}, w1};

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int k = 0; k < MUL_LAT; k++) begin
          mp[k] <= '0;
          ad[k] <= '0;
          sd[k] <= '0;
          dd[k] <= '0;
        end
      end else if (in_ready) begin
        mp[0] <= DW'(prod % QP);
        ad[0] <= a1;
        sd[0] <= s1;
        dd[0] <= d1;
        for (int k = 1; k < MUL_LAT; k++) begin
          mp[k] <= mp[k-1];
          ad[k] <= ad[k-1];
          sd[k] <= sd[k-1];
          dd[k] <= dd[k-1];
        end
      end
    end

    assign pm = mp[MUL_LAT-1];
    assign am = ad[MUL_LAT-1];

    always_comb begin
      ce = pm;
      co = '0;
      case (mm[MUL_LAT-1])
        MODE_CT: begin
          ce = mod_add(am, pm);
          co = mod_sub(am, pm);
        end
        MODE_GS: begin
          ce = sd[MUL_LAT-1];
          co = pm;
        end
        MODE_AS: begin
          ce = sd[MUL_LAT-1];
          co = dd[MUL_LAT-1];
        end
        default: begin
          ce = pm;
          co = '0;
        end
      endcase
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        ce_r <= '0;
        co_r <= '0;
        e_r  <= '0;
        o_r  <= '0;
      end else if (in_ready) begin
        ce_r <= ce;
        co_r <= co;
        e_r  <= (mc == MODE_GS) ? mod_half(ce_r) : ce_r;
        o_r  <= (mc == MODE_GS) ? mod_half(co_r) : co_r;
      end
    end

    assign e[i*DW +: DW] = e_r;
    assign o[i*DW +: DW] = o_r;
  end

endmodule
`default_nettype wire

// File: tb/tb_bfly_lanes_pipe.sv
`default_nettype none
`timescale 1ns/1ps
// Scoreboard bench for bfly_lanes_pipe: driver pushes expected beats, a negedge monitor
// pops and compares whenever out_valid is presented.
module tb_bfly_lanes_pipe;
  localparam int DW = 12, Q = 3329, LANES = 2, MUL_LAT = 3, LAT = MUL_LAT + 2;
  localparam int W = LANES * DW;
  localparam int INV2 = (Q + 1) / 2;

  logic         clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1, clr_err = 1'b0;
  logic [1:0]   mode = '0;
  logic [W-1:0] a = '0, b = '0, w = '0;
  logic         in_ready, out_valid, range_err;
  logic [W-1:0] e, o;
  logic [1:0]   out_mode;

  typedef struct {
    logic [1:0]   m;
    logic [W-1:0] e;
    logic [W-1:0] o;
    bit           dc;
    bit           lat;
    int           t;
  } exp_t;

  exp_t q[$];
  exp_t hd;
  int   n_checks = 0, n_fail = 0, cyc = 0;
  bit   rand_done = 1'b0;

  bfly_lanes_pipe #(.DW(DW), .Q(Q), .LANES(LANES), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .a(a), .b(b), .w(w), .out_valid(out_valid), .out_ready(out_ready),
    .e(e), .o(o), .out_mode(out_mode), .range_err(range_err), .clr_err(clr_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void gold(input int m, input int ai, input int bi, input int wi,
                               output int ei, output int oi);
    int p;
    case (m)
      0: begin p = (bi * wi) % Q; ei = (ai + p) % Q; oi = (ai - p + Q) % Q; end
      1: begin
        ei = (((ai + bi) % Q) * INV2) % Q;
        oi = (((((ai - bi + Q) % Q) * wi) % Q) * INV2) % Q;
      end
      2: begin ei = (ai + bi) % Q; oi = (ai - bi + Q) % Q; end
      default: begin ei = (bi * wi) % Q; oi = 0; end
    endcase
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [1:0] m, input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic [W-1:0] wv, input logic [W-1:0] ee, input logic [W-1:0] oe,
                      input bit dc, input bit lat);
    int g = 0;
    in_valid = 1'b1; mode = m; a = av; b = bv; w = wv;
    @(negedge clk);
    while (!in_ready && g < 200) begin @(negedge clk); g++; end
    if (!in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: in_ready stuck at %b after %0d cycles", in_ready, g);
    end else begin
      q.push_back('{m, ee, oe, dc, lat, cyc + 1});
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic rand_beat(input bit lat);
    logic [1:0]   m;
    logic [W-1:0] av, bv, wv, ev, ov;
    int ai, bi, wi, ei, oi;
    m = 2'($urandom_range(0, 3));
    for (int l = 0; l < LANES; l++) begin
      ai = int'($urandom_range(0, Q - 1));
      bi = int'($urandom_range(0, Q - 1));
      wi = int'($urandom_range(0, Q - 1));
      gold(int'(m), ai, bi, wi, ei, oi);
      av[l*DW +: DW] = DW'(ai); bv[l*DW +: DW] = DW'(bi); wv[l*DW +: DW] = DW'(wi);
      ev[l*DW +: DW] = DW'(ei); ov[l*DW +: DW] = DW'(oi);
    end
    send(m, av, bv, wv, ev, ov, 1'b0, lat);
  endtask

  task automatic drain();
    int g = 0;
    while (q.size() != 0 && g < 300) begin @(negedge clk); g++; end
    if (q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout: %0d beats outstanding, expected 0", q.size());
    end
    @(posedge clk); #1;
  endtask

  // Monitor: the head of the queue must be on the outputs whenever out_valid is high,
  // including every stalled cycle.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_beat: got mode %0d e %h o %h, expected no beat", out_mode, e, o);
      end else begin
        hd = q[0];
        check("out_mode", W'(out_mode), W'(hd.m));
        if (!hd.dc) begin
          check("e", e, hd.e);
          check("o", o, hd.o);
        end
        if (out_ready) begin
          if (hd.lat) check("latency", W'(cyc - hd.t), W'(LAT));
          void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d beats outstanding", q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk); #1;
    check("rst_out_valid", W'(out_valid), '0);
    check("rst_in_ready", W'(in_ready), W'(1));
    check("rst_range_err", W'(range_err), '0);
    check("rst_out_mode", W'(out_mode), '0);
    check("rst_e", e, '0);
    check("rst_o", o, '0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Back-to-back CT, GS, add/sub, mult; then boundary CT and GS.
    send(2'b00, {12'd0, 12'd1}, {12'd3328, 12'd2}, {12'd3328, 12'd3},
         {12'd1, 12'd7}, {12'd3328, 12'd3324}, 1'b0, 1'b1);
    send(2'b01, {12'd5, 12'd1}, {12'd3, 12'd0}, {12'd2, 12'd1},
         {12'd4, 12'd1665}, {12'd2, 12'd1665}, 1'b0, 1'b1);
    send(2'b10, {12'd3328, 12'd0}, {12'd3328, 12'd1}, {12'd5, 12'd77},
         {12'd3327, 12'd1}, {12'd0, 12'd3328}, 1'b0, 1'b1);
    send(2'b11, {12'd0, 12'd9}, {12'd2, 12'd3328}, {12'd1665, 12'd3328},
         {12'd1, 12'd1}, {12'd0, 12'd0}, 1'b0, 1'b1);
    send(2'b00, {12'd0, 12'd3328}, {12'd0, 12'd1}, {12'd0, 12'd1},
         {12'd0, 12'd0}, {12'd0, 12'd3327}, 1'b0, 1'b1);
    send(2'b01, {12'd3328, 12'd0}, {12'd3328, 12'd1}, {12'd3328, 12'd1},
         {12'd3328, 12'd1665}, {12'd0, 12'd1664}, 1'b0, 1'b1);
    drain();

    // Range error: set, sticky, clear, ignored operand, set-wins-over-clear.
    send(2'b00, {12'd0, 12'd3329}, {12'd1, 12'd1}, {12'd1, 12'd1}, '0, '0, 1'b1, 1'b1);
    check("range_set", W'(range_err), W'(1));
    repeat (3) @(posedge clk); #1;
    check("range_sticky", W'(range_err), W'(1));
    clr_err = 1'b1; @(posedge clk); #1; clr_err = 1'b0;
    check("range_clr", W'(range_err), '0);
    send(2'b11, {12'd4095, 12'd4095}, {12'd1, 12'd2}, {12'd1, 12'd3},
         {12'd1, 12'd6}, {12'd0, 12'd0}, 1'b0, 1'b1);
    check("range_a_ignored", W'(range_err), '0);
    clr_err = 1'b1;
    send(2'b10, {12'd1, 12'd1}, {12'd4000, 12'd0}, {12'd4095, 12'd0}, '0, '0, 1'b1, 1'b1);
    clr_err = 1'b0;
    check("range_set_wins", W'(range_err), W'(1));
    clr_err = 1'b1; @(posedge clk); #1; clr_err = 1'b0;
    check("range_clr2", W'(range_err), '0);
    drain();

    // Stall with a full pipe for 7 cycles.
    out_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 10; k++) rand_beat(1'b0);
      end
      begin
        int g = 0;
        while (!out_valid && g < 100) begin @(negedge clk); g++; end
        check("stall_fill", W'(out_valid), W'(1));
        check("stall_in_ready", W'(in_ready), '0);
        for (int k = 0; k < 6; k++) begin
          @(negedge clk);
          check("stall_in_ready", W'(in_ready), '0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Asynchronous reset with beats in flight and one on the output.
    for (int k = 0; k < 6; k++) rand_beat(1'b0);
    rst = 1'b1;
    #1;
    check("rst_async_out_valid", W'(out_valid), '0);
    check("rst_async_in_ready", W'(in_ready), W'(1));
    q.delete();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    send(2'b10, {12'd10, 12'd0}, {12'd20, 12'd1}, {12'd0, 12'd0},
         {12'd30, 12'd1}, {12'd3319, 12'd3328}, 1'b0, 1'b1);
    repeat (12) @(posedge clk); #1;
    drain();

    // Random stream against the golden model with random backpressure and bubbles.
    fork
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
      begin
        for (int k = 0; k < 1000; k++) begin
          rand_beat(1'b0);
          if ($urandom_range(0, 4) == 0) begin @(posedge clk); #1; end
        end
        rand_done = 1'b1;
      end
    join
    out_ready = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bfly_lanes_pipe.md
BFLY_LANES_PIPE -- requirements
Module: bfly_lanes_pipe

Interface
REQ-001 Parameter DW, default 12, coefficient width in bits.
REQ-002 Parameter Q, default 3329, modulus; SHALL satisfy 2 < Q < 2^DW and Q odd.
REQ-003 Parameter LANES, default 2, number of independent butterfly lanes sharing one control path.
REQ-004 Parameter MUL_LAT, default 3, internal modular-multiplier pipeline depth, >= 1; total latency LAT = MUL_LAT + 2.
REQ-005 clk  input  1  clock; all state on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 in_valid  input  1  beat present on a, b, w, mode.
REQ-008 in_ready  output  1  beat accepted when in_valid && in_ready.
REQ-009 mode  input  2  00 CT butterfly, 01 GS butterfly, 10 mod add/sub, 11 mod mult.
REQ-010 a, b, w  input  LANES*DW each  lane i occupies bits [i*DW +: DW].
REQ-011 out_valid  output  1  result beat present on e, o, out_mode.
REQ-012 out_ready  input  1  downstream accepts when out_valid && out_ready.
REQ-013 e, o  output  LANES*DW each  per-lane results, same lane packing as inputs.
REQ-014 out_mode  output  2  mode of the beat currently on e/o.
REQ-015 range_err  output  1  sticky: some accepted operand was >= Q.
REQ-016 clr_err  input  1  synchronous clear of range_err.

Function
REQ-017 Per lane, with operands in [0,Q-1], CT SHALL give e=(a+b*w) mod Q, o=(a-b*w) mod Q.
REQ-018 GS SHALL give e=((a+b)*inv2) mod Q, o=((a-b)*w*inv2) mod Q, with inv2=(Q+1)/2; halving is implemented as x even ? x>>1 : (x+Q)>>1.
REQ-019 Mode 10 SHALL give e=(a+b) mod Q, o=(a-b) mod Q; w ignored.
REQ-020 Mode 11 SHALL give e=(b*w) mod Q, o=0; a ignored.
REQ-021 Every output value SHALL be fully reduced to [0,Q-1]; no lazy reduction.
REQ-022 Every mode SHALL have identical latency LAT: a beat accepted at edge n appears with out_valid at edge n+LAT absent stalls.
REQ-023 Mode SHALL travel with its beat through the pipeline; consecutive beats of different modes SHALL each compute correctly with no bubbles.
REQ-024 One multiplier per lane SHALL be shared by CT (b*w), GS ((a-b)*w) and mode 11 (b*w); operand alignment SHALL use pipeline delay registers.
REQ-025 Global stall: in_ready = out_ready || !out_valid; when in_ready is 0 every pipeline register, valid bit and mode tag SHALL hold.
REQ-026 While out_valid && !out_ready, e, o, out_mode SHALL remain stable until accepted.
REQ-027 Bubbles (in_valid=0 on an advancing cycle) SHALL propagate as invalid slots; out_valid SHALL never assert for a bubble.
REQ-028 Throughput SHALL be one beat per cycle per lane when out_ready is held 1.
REQ-029 range_err SHALL set the cycle after accepting a beat with any lane of a or b or w >= Q (only operands used by that mode checked); results for such beats are unspecified but the beat SHALL still emerge.
REQ-030 clr_err and a new range violation in the same cycle: set wins.

Reset
REQ-031 On rst: out_valid=0, range_err=0, out_mode=00, e=o=0, all pipeline valid bits cleared; in-flight beats discarded.
REQ-032 in_ready SHALL be 1 during and after reset; first beat accepted on the first edge after rst deasserts.

Verification (Q=3329, LANES=2, MUL_LAT=3, LAT=5)
REQ-033 CT lane0 a=1,b=2,w=3, lane1 a=0,b=3328,w=3328 -> after 5 cycles e={1,7}, o={3328,3324} (lane1,lane0).
REQ-034 GS a=1,b=0,w=1 -> e=1665, o=1665; GS a=5,b=3,w=2 -> e=4, o=2.
REQ-035 Back-to-back beats modes 00,01,10,11 (a=0,b=1,w=1 for 10: e=1,o=3328; b=3328,w=3328 for 11: e=1,o=0) -> four consecutive out_valid cycles, correct out_mode tags.
REQ-036 out_ready=0 for 7 cycles with pipeline full -> in_ready=0, outputs frozen, no beat lost or duplicated after release; 1000-beat random stream matches golden model.
REQ-037 rst pulsed with 3 beats in flight -> out_valid=0 immediately, none of those beats ever emerge.
REQ-038 Beat with a=3329 -> range_err=1 next cycle, stays 1 until clr_err; clr_err concurrent with new violation -> remains 1.
